// File: rtl/reg_file_sweep_pkg.sv
// Shared types and defaults for the sweeping register file.
package reg_file_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  localparam int DW_DEF = 8;
  localparam int PW_DEF = 4;

endpackage

// File: rtl/reg_file_sweep_if.sv
// Decode/writeback-side bus of the sweeping register file.
interface reg_file_sweep_if #(
  parameter int DW = 8,
  parameter int PW = 4
);
  logic          clr_req;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [DW-1:0] dat_in;
  logic [PW-1:0] rd_addrA;
  logic [PW-1:0] rd_addrB;
  logic [DW-1:0] datA_out;
  logic [DW-1:0] datB_out;
  logic          ready;
  logic          wr_lost;

  modport master (
    output clr_req, wr_en, wr_addr, dat_in, rd_addrA, rd_addrB,
    input  datA_out, datB_out, ready, wr_lost
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, dat_in, rd_addrA, rd_addrB,
    output datA_out, datB_out, ready, wr_lost
  );
endinterface

// File: rtl/reg_file_sweep_rf_init_seq.sv
// Init sequencer: sweeps every entry to the init value after reset or clear,
// then hands the file over to normal operation.
//   state   | meaning
//   RF_INIT | sweeping entry sp_q, user writes dropped, reads forced
//   RF_RUN  | sweep done, normal read/write
module rf_init_seq
  import reg_file_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req_i,
  input  logic          wr_en_i,
  output logic          sweep_we_o,
  output logic [PW-1:0] sweep_addr_o,
  output logic          ready_o,
  output logic          wr_lost_o
);

  rf_state_t     state_q;
  logic [PW-1:0] sp_q;
  logic          ready_q;
  logic          wr_lost_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RF_INIT;
      sp_q      <= '0;
      ready_q   <= 1'b0;
      wr_lost_q <= 1'b0;
    end else begin
      // a write coinciding with a clear is dropped just like one during the sweep
      if (wr_en_i && (clr_req_i || state_q == RF_INIT)) wr_lost_q <= 1'b1;
      if (clr_req_i) begin
        state_q <= RF_INIT;
        sp_q    <= '0;
        ready_q <= 1'b0;
      end else if (state_q == RF_INIT) begin
        if (&sp_q) begin
          state_q <= RF_RUN;
          ready_q <= 1'b1;
        end else begin
          sp_q <= sp_q + PW'(1);
        end
      end
    end
  end

  assign sweep_we_o   = rst_n && (state_q == RF_INIT) && !clr_req_i;
  assign sweep_addr_o = sp_q;
  assign ready_o      = ready_q;
  assign wr_lost_o    = wr_lost_q;

endmodule

// File: rtl/reg_file_sweep.sv
// Parametrised 2-read/1-write register file with init sweep and optional
// write-to-read bypass.
module reg_file_sweep
  import reg_file_pkg::*;
#(
  parameter int            DW       = DW_DEF,
  parameter int            PW       = PW_DEF,
  parameter logic [DW-1:0] INIT_VAL = '0,
  parameter bit            BYPASS   = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  reg_file_sweep_if.slave bus
);

  localparam int DEPTH = 2 ** PW;

  logic [DW-1:0] mem_q [DEPTH];
  logic          sweep_we;
  logic [PW-1:0] sweep_addr;
  logic          ready;
  logic          wr_lost;
  logic          user_we;
  logic [DW-1:0] dat_a;
  logic [DW-1:0] dat_b;

  rf_init_seq #(.PW(PW)) u_init_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_req_i    (bus.clr_req),
    .wr_en_i      (bus.wr_en),
    .sweep_we_o   (sweep_we),
    .sweep_addr_o (sweep_addr),
    .ready_o      (ready),
    .wr_lost_o    (wr_lost)
  );

  assign user_we = rst_n && ready && bus.wr_en && !bus.clr_req;

  // storage is deliberately left out of reset; the sweep initialises it
  always_ff @(posedge clk) begin
    if (sweep_we)     mem_q[sweep_addr]  <= INIT_VAL;
    else if (user_we) mem_q[bus.wr_addr] <= bus.dat_in;
  end

  always_comb begin
    dat_a = mem_q[bus.rd_addrA];
    if (BYPASS && bus.wr_en && (bus.rd_addrA == bus.wr_addr)) dat_a = bus.dat_in;
    if (!ready) dat_a = INIT_VAL;
  end

  always_comb begin
    dat_b = mem_q[bus.rd_addrB];
    if (BYPASS && bus.wr_en && (bus.rd_addrB == bus.wr_addr)) dat_b = bus.dat_in;
    if (!ready) dat_b = INIT_VAL;
  end

  assign bus.datA_out = dat_a;
  assign bus.datB_out = dat_b;
  assign bus.ready    = ready;
  assign bus.wr_lost  = wr_lost;

endmodule

// File: tb/tb_reg_file_sweep.sv
// Bench for reg_file_sweep: one instance without and one with bypass, driven
// with identical stimulus and checked against a bench-side model.
module tb_reg_file_sweep;

  localparam logic [7:0] IV = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_file_sweep_if #(.DW(8), .PW(4)) if0 ();
  reg_file_sweep_if #(.DW(8), .PW(4)) if1 ();

  assign if1.clr_req  = if0.clr_req;
  assign if1.wr_en    = if0.wr_en;
  assign if1.wr_addr  = if0.wr_addr;
  assign if1.dat_in   = if0.dat_in;
  assign if1.rd_addrA = if0.rd_addrA;
  assign if1.rd_addrB = if0.rd_addrB;

  reg_file_sweep #(.DW(8), .PW(4), .INIT_VAL(IV), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  reg_file_sweep #(.DW(8), .PW(4), .INIT_VAL(IV), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  typedef struct {
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  typedef struct {
    string      nm;
    logic [7:0] exp;
  } sb_t;

  vec_t       vt [16];
  sb_t        sbq [$];
  logic [7:0] model [16];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input string nm, input logic [7:0] exp);
    sb_t e;
    e.nm  = nm;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic sb_pop_chk(input logic [7:0] act);
    sb_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_underflow: got %h want none", act);
    end else begin
      e = sbq.pop_front();
      chk(e.nm, act, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_from_model();
    for (int i = 0; i < 16; i++) begin
      vt[i].ra = 4'(i);
      vt[i].rb = 4'(15 - i);
      vt[i].ea = model[i];
      vt[i].eb = model[15 - i];
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      if0.rd_addrA = vt[i].ra;
      if0.rd_addrB = vt[i].rb;
      sb_push($sformatf("%s[%0d].A0", tag, i), vt[i].ea);
      sb_push($sformatf("%s[%0d].B0", tag, i), vt[i].eb);
      sb_push($sformatf("%s[%0d].A1", tag, i), vt[i].ea);
      sb_push($sformatf("%s[%0d].B1", tag, i), vt[i].eb);
      @(negedge clk);
      sb_pop_chk(if0.datA_out);
      sb_pop_chk(if0.datB_out);
      sb_pop_chk(if1.datA_out);
      sb_pop_chk(if1.datB_out);
    end
  endtask

  task automatic sweep_watch(input string tag);
    for (int e = 1; e <= 16; e++) begin
      step();
      chk($sformatf("%s_ready0[%0d]", tag, e), {7'b0, if0.ready}, {7'b0, e == 16});
      chk($sformatf("%s_ready1[%0d]", tag, e), {7'b0, if1.ready}, {7'b0, e == 16});
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d,
                          input logic [3:0] ra, input logic [3:0] rb);
    if0.wr_en    = 1'b1;
    if0.wr_addr  = a;
    if0.dat_in   = d;
    if0.rd_addrA = ra;
    if0.rd_addrB = rb;
    #1;
    chk($sformatf("wr%0d_same_A0", a), if0.datA_out, model[ra]);
    chk($sformatf("wr%0d_same_B0", a), if0.datB_out, model[rb]);
    chk($sformatf("wr%0d_same_A1", a), if1.datA_out, (ra == a) ? d : model[ra]);
    chk($sformatf("wr%0d_same_B1", a), if1.datB_out, (rb == a) ? d : model[rb]);
    step();
    if0.wr_en = 1'b0;
    model[a]  = d;
    #1;
    chk($sformatf("wr%0d_next_A0", a), if0.datA_out, model[ra]);
    chk($sformatf("wr%0d_next_B0", a), if0.datB_out, model[rb]);
    chk($sformatf("wr%0d_next_A1", a), if1.datA_out, model[ra]);
    chk($sformatf("wr%0d_next_B1", a), if1.datB_out, model[rb]);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n        = 1'b0;
    if0.clr_req  = 1'b0;
    if0.wr_en    = 1'b0;
    if0.wr_addr  = '0;
    if0.dat_in   = '0;
    if0.rd_addrA = '0;
    if0.rd_addrB = 4'd7;
    for (int i = 0; i < 16; i++) model[i] = IV;

    // reset state
    step();
    step();
    chk("rst_ready0", {7'b0, if0.ready}, 8'd0);
    chk("rst_ready1", {7'b0, if1.ready}, 8'd0);
    chk("rst_lost0", {7'b0, if0.wr_lost}, 8'd0);
    chk("rst_lost1", {7'b0, if1.wr_lost}, 8'd0);
    chk("rst_forceA0", if0.datA_out, IV);
    chk("rst_forceB1", if1.datB_out, IV);

    // sweep after reset, with a dropped write on sweep edge 4
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      if (e == 4) begin
        if0.wr_en   = 1'b1;
        if0.wr_addr = 4'd1;
        if0.dat_in  = 8'hFF;
      end
      step();
      if0.wr_en = 1'b0;
      chk($sformatf("sweep_ready0[%0d]", e), {7'b0, if0.ready}, {7'b0, e == 16});
      chk($sformatf("sweep_ready1[%0d]", e), {7'b0, if1.ready}, {7'b0, e == 16});
      if (e == 4) chk("drop_lost0", {7'b0, if0.wr_lost}, 8'd1);
    end
    chk("drop_lost0_sticky", {7'b0, if0.wr_lost}, 8'd1);
    chk("drop_lost1_sticky", {7'b0, if1.wr_lost}, 8'd1);
    fill_from_model();
    run_table("init");

    // writes in RUN: same-cycle old/bypass value, then the stored value
    do_write(4'd5,  8'h3C, 4'd5,  4'd4);
    do_write(4'd2,  8'h77, 4'd2,  4'd3);
    do_write(4'd6,  8'h5A, 4'd6,  4'd6);
    do_write(4'd8,  8'hC3, 4'd0,  4'd8);
    do_write(4'd9,  8'h12, 4'd9,  4'd1);
    do_write(4'd15, 8'hEE, 4'd14, 4'd15);
    do_write(4'd0,  8'h01, 4'd0,  4'd15);
    fill_from_model();
    run_table("run");

    // clear request in RUN with a colliding write, then a restart mid-sweep
    if0.rd_addrA = 4'd9;
    if0.rd_addrB = 4'd15;
    if0.clr_req  = 1'b1;
    if0.wr_en    = 1'b1;
    if0.wr_addr  = 4'd9;
    if0.dat_in   = 8'h99;
    step();
    if0.clr_req = 1'b0;
    if0.wr_en   = 1'b0;
    chk("clr_ready0", {7'b0, if0.ready}, 8'd0);
    chk("clr_ready1", {7'b0, if1.ready}, 8'd0);
    chk("clr_forceA0", if0.datA_out, IV);
    chk("clr_forceB1", if1.datB_out, IV);
    repeat (5) step();
    chk("clr_mid_ready0", {7'b0, if0.ready}, 8'd0);
    if0.clr_req = 1'b1;
    step();
    if0.clr_req = 1'b0;
    sweep_watch("clr");
    chk("clr_lost0_kept", {7'b0, if0.wr_lost}, 8'd1);
    chk("clr_lost1_kept", {7'b0, if1.wr_lost}, 8'd1);
    for (int i = 0; i < 16; i++) model[i] = IV;
    fill_from_model();
    run_table("clr");

    // reset on sweep edge 10
    if0.clr_req = 1'b1;
    step();
    if0.clr_req = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_ready0", {7'b0, if0.ready}, 8'd0);
    chk("midrst_lost0", {7'b0, if0.wr_lost}, 8'd0);
    sweep_watch("midrst");
    chk("midrst_lost0_end", {7'b0, if0.wr_lost}, 8'd0);
    chk("midrst_lost1_end", {7'b0, if1.wr_lost}, 8'd0);
    run_table("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
